block_shift_engine: RTL and testbench



---
 rtl/game_pkg.sv | 27 ++
 rtl/edge_detect_rise.sv | 19 +
 rtl/block_shift_engine.sv | 149 ++++++++++++++
 tb/tb_block_shift_engine.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the stacker-game row logic.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam int unsigned MASK_MAX = 64;

  // Left-aligned run of n ones inside a width-bit field (bits width-1..width-n).
  function automatic logic [MASK_MAX-1:0] left_mask(input int unsigned width,
                                                    input int unsigned n);
    logic [MASK_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX; i++) begin
      if ((i < width) && ((i + n) >= width)) m[i] = 1'b1;
      else                                  m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector: rise is high while din is high and was low last cycle.
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;

  // Remember last cycle's level of din.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/block_shift_engine.sv
// Stacker-game block shifter: moves a run of lit cells along a row and freezes it on a stop press.
// Optional macro BLOCK_SHIFT_BOUNCE_EN switches from wrap-around rotation to ping-pong motion.
module block_shift_engine
  import game_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_in,
  input  logic             step_pulse,
  input  logic             stop_btn,
  output logic [WIDTH-1:0] block_loc,
  output logic             moving,
  output logic             locked,
  output logic [WIDTH-1:0] locked_loc
);

  localparam int unsigned WIDTH_U = WIDTH;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    loc_nxt, locked_loc_nxt, shifted, start_mask;
  logic [MASK_MAX-1:0] full_mask;
  logic                locked_nxt, stop_edge;
  int unsigned         len_req, len_eff;
`ifdef BLOCK_SHIFT_BOUNCE_EN
  logic                dir, dir_nxt, dir_step;
`endif

  edge_detect_rise u_stop_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (stop_btn),
    .rise (stop_edge)
  );

  // Clamp the requested run length to 1..WIDTH and build the start pattern.
  always_comb begin
    len_req = 32'(len_in);
    if (len_req == 32'd0)       len_eff = 32'd1;
    else if (len_req > WIDTH_U) len_eff = WIDTH_U;
    else                        len_eff = len_req;
    full_mask  = left_mask(WIDTH_U, len_eff);
    start_mask = full_mask[WIDTH-1:0];
  end

`ifdef BLOCK_SHIFT_BOUNCE_EN
  // Ping-pong step: reverse at either edge in the same step, full row never moves.
  always_comb begin
    dir_step = dir;
    shifted  = block_loc;
    if (&block_loc) begin
      dir_step = dir;
      shifted  = block_loc;
    end else if (dir == DIR_RIGHT) begin
      if (block_loc[0]) begin
        dir_step = DIR_LEFT;
        shifted  = {block_loc[WIDTH-2:0], 1'b0};
      end else begin
        shifted  = {1'b0, block_loc[WIDTH-1:1]};
      end
    end else begin
      if (block_loc[WIDTH-1]) begin
        dir_step = DIR_RIGHT;
        shifted  = {1'b0, block_loc[WIDTH-1:1]};
      end else begin
        shifted  = {block_loc[WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  // Wrap step: rotate right, an all-ones run is naturally unchanged.
  always_comb begin
    shifted = {block_loc[0], block_loc[WIDTH-1:1]};
  end
`endif

  // Next-state and next-output decode; start outranks stop, which outranks step.
  always_comb begin
    state_nxt      = state;
    loc_nxt        = block_loc;
    locked_loc_nxt = locked_loc;
    locked_nxt     = 1'b0;
`ifdef BLOCK_SHIFT_BOUNCE_EN
    dir_nxt        = dir;
`endif
    if (start) begin
      state_nxt      = MOVING;
      loc_nxt        = start_mask;
      locked_loc_nxt = '0;
`ifdef BLOCK_SHIFT_BOUNCE_EN
      dir_nxt        = DIR_RIGHT;
`endif
    end else begin
      case (state)
        IDLE: begin
          loc_nxt = '0;
        end
        MOVING: begin
          if (stop_edge) begin
            state_nxt      = LOCKED;
            locked_loc_nxt = block_loc;
            locked_nxt     = 1'b1;
          end else if (step_pulse) begin
            loc_nxt = shifted;
`ifdef BLOCK_SHIFT_BOUNCE_EN
            dir_nxt = dir_step;
`endif
          end else begin
            loc_nxt = block_loc;
          end
        end
        LOCKED: begin
          loc_nxt = block_loc;
        end
        default: begin
          state_nxt = IDLE;
          loc_nxt   = '0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      block_loc  <= '0;
      moving     <= 1'b0;
      locked     <= 1'b0;
      locked_loc <= '0;
`ifdef BLOCK_SHIFT_BOUNCE_EN
      dir        <= DIR_RIGHT;
`endif
    end else begin
      state      <= state_nxt;
      block_loc  <= loc_nxt;
      moving     <= (state_nxt == MOVING);
      locked     <= locked_nxt;
      locked_loc <= locked_loc_nxt;
`ifdef BLOCK_SHIFT_BOUNCE_EN
      dir        <= dir_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_block_shift_engine.sv
// Bench for block_shift_engine: position/length model of the run plus directed and random stimulus.
module tb_block_shift_engine;

  localparam int W  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len_in = '0;
  logic          step_pulse = 1'b0;
  logic          stop_btn = 1'b0;
  logic [W-1:0]  block_loc;
  logic          moving;
  logic          locked;
  logic [W-1:0]  locked_loc;

  block_shift_engine #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len_in     (len_in),
    .step_pulse (step_pulse),
    .stop_btn   (stop_btn),
    .block_loc  (block_loc),
    .moving     (moving),
    .locked     (locked),
    .locked_loc (locked_loc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 1'b0;

  // Model: run described by leftmost cell index (0 = leftmost), length and direction.
  int           m_state = 0;   // 0 idle, 1 moving, 2 locked
  int           m_pos = 0;
  int           m_len = 1;
  int           m_dir = 0;     // 0 right, 1 left
  logic         m_prev = 1'b0;
  logic [W-1:0] m_loc = '0;
  logic         m_moving = 1'b0;
  logic         m_locked = 1'b0;
  logic [W-1:0] m_locked_loc = '0;

  function automatic logic [W-1:0] pattern(input int pos, input int len);
    logic [W-1:0] p;
    p = '0;
    for (int k = 0; k < len; k++) p[W-1-((pos + k) % W)] = 1'b1;
    return p;
  endfunction

  task automatic model_step(input logic r, s, input logic [LW-1:0] l, input logic st, sp);
    logic edge_now;
    edge_now = sp & ~m_prev;
    m_prev   = sp;
    m_locked = 1'b0;
    if (r) begin
      m_state = 0; m_pos = 0; m_len = 1; m_dir = 0; m_prev = 1'b0;
      m_locked_loc = '0;
    end else if (s) begin
      m_len = (int'(l) == 0) ? 1 : ((int'(l) > W) ? W : int'(l));
      m_pos = 0; m_dir = 0; m_state = 1; m_locked_loc = '0;
    end else if (m_state == 1 && edge_now) begin
      m_state = 2; m_locked = 1'b1; m_locked_loc = pattern(m_pos, m_len);
    end else if (m_state == 1 && st && m_len < W) begin
`ifdef BLOCK_SHIFT_BOUNCE_EN
      if (m_dir == 0) begin
        if (m_pos + m_len == W) begin m_dir = 1; m_pos = m_pos - 1; end
        else m_pos = m_pos + 1;
      end else begin
        if (m_pos == 0) begin m_dir = 0; m_pos = m_pos + 1; end
        else m_pos = m_pos - 1;
      end
`else
      m_pos = (m_pos + 1) % W;
`endif
    end
    m_loc    = (m_state == 0) ? '0 : pattern(m_pos, m_len);
    m_moving = (m_state == 1);
  endtask

  task automatic cyc(input logic r, s, input logic [LW-1:0] l, input logic st, sp);
    rst = r; start = s; len_in = l; step_pulse = st; stop_btn = sp;
    @(posedge clk);
    model_step(r, s, l, st, sp);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Literal pin: both the model and the DUT must show the hand-computed pattern.
  task automatic pin_loc(input string name, input logic [W-1:0] exp);
    check({name, "_model"}, 32'(m_loc), 32'(exp));
    check({name, "_dut"}, 32'(block_loc), 32'(exp));
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (armed) begin
      n_vec++;
      if (block_loc !== m_loc || moving !== m_moving || locked !== m_locked ||
          locked_loc !== m_locked_loc) begin
        n_err++;
        $display("FAIL cycle t=%0t: loc=%h/%h moving=%b/%b locked=%b/%b locked_loc=%h/%h (got/expected)",
                 $time, block_loc, m_loc, moving, m_moving, locked, m_locked, locked_loc, m_locked_loc);
      end
    end
  end

  initial begin
    logic [W-1:0] e;
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    armed = 1'b1;
    check("reset_loc", 32'(block_loc), 32'h0);
    check("reset_moving", 32'(moving), 32'h0);
    check("reset_locked_loc", 32'(locked_loc), 32'h0);

    cyc(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    pin_loc("len1_start", 8'h80);
    check("len1_moving", 32'(moving), 32'h1);
`ifndef BLOCK_SHIFT_BOUNCE_EN
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      e = 8'h80;
      e = e >> ((i + 1) % 8);
      pin_loc("len1_wrap", e);
      check("len1_wrap_moving", 32'(moving), 32'h1);
    end
    cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    pin_loc("len3_start", 8'hE0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    pin_loc("len3_5steps", 8'h07);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    pin_loc("len3_wrap", 8'h83);
`endif

    cyc(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    pin_loc("lock_pre", 8'h10);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    pin_loc("lock_noshift", 8'h10);
    check("lock_pulse", 32'(locked), 32'h1);
    check("lock_loc", 32'(locked_loc), 32'h10);
    check("lock_moving", 32'(moving), 32'h0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("lock_pulse_end", 32'(locked), 32'h0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    pin_loc("locked_hold", 8'h10);
    check("locked_loc_hold", 32'(locked_loc), 32'h10);
    check("relock_none", 32'(locked), 32'h0);

    cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    pin_loc("len0_clamp", 8'h80);
    check("start_clears_locked_loc", 32'(locked_loc), 32'h0);
    cyc(1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
    pin_loc("len12_clamp", 8'hFF);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    pin_loc("full_stays", 8'hFF);

`ifdef BLOCK_SHIFT_BOUNCE_EN
    cyc(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    pin_loc("bounce_start", 8'hC0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    pin_loc("bounce_right_end", 8'h03);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    pin_loc("bounce_flip", 8'h06);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    pin_loc("bounce_left", 8'h0C);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    pin_loc("bounce_left_end", 8'hC0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    pin_loc("bounce_flip2", 8'h60);
`endif

    cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    pin_loc("midrun_rst", 8'h00);
    check("midrun_rst_moving", 32'(moving), 32'h0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    pin_loc("idle_ignores", 8'h00);

    cyc(1'b0, 1'b1, 4'd2, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("held_stop_no_lock", 32'(moving), 32'h1);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("fresh_press_lock", 32'(locked), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      logic r, s, st, sp;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 2) == 0);
      sp = ($urandom_range(0, 7) == 0) ? ~stop_btn : stop_btn;
      cyc(r, s, 4'($urandom_range(0, 15)), st, sp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
